// File: rtl/acc_pkg.sv
// acc_pkg: state encoding, bus direction and data width shared by the sequencer and the accumulator
package acc_pkg;
  localparam int DW = 8;
  localparam logic BUS_READ = 1'b1;
  localparam logic BUS_WRITE = 1'b0;
  typedef enum logic [2:0] {INIT, PARK, WRITE, GAP, DRAIN, READ} state_t;
endpackage

// File: rtl/accumulator_sequencer.sv
// accumulator_sequencer: feeds N_OPS-operand batches to the 8-bit accumulator and returns each batch sum
module accumulator_sequencer
  import acc_pkg::*;
#(
  parameter int N_OPS = 4,
  parameter int CW = 8
) (
  input  logic          Clk,
  input  logic          nRst,
  input  logic [DW-1:0] In_Data,
  input  logic          In_Valid,
  output logic          In_Ready,
  output logic [DW-1:0] Out_Data,
  output logic          Out_Valid,
  input  logic          Out_Ready,
  output logic          Sel,
  output logic          RnW,
  inout  wire  [DW-1:0] Dio
);
  state_t state, nxt;
  logic [CW-1:0] count;
  logic [DW-1:0] op;
  logic last;
  assign last = count == CW'(N_OPS - 1);
  assign Dio = (state == WRITE) ? op : 'z;
  always_comb begin
    nxt = state;
    Sel = 1'b0;
    RnW = BUS_READ;
    In_Ready = 1'b0;
    unique case (state)
      INIT: begin
        Sel = 1'b1;
        nxt = PARK;
      end
      PARK: begin
        Sel = 1'b1;
        In_Ready = 1'b1;
        nxt = In_Valid ? WRITE : PARK;
      end
      WRITE: begin
        Sel = 1'b1;
        RnW = BUS_WRITE;
        nxt = last ? DRAIN : GAP;
      end
      GAP: begin
        In_Ready = 1'b1;
        nxt = In_Valid ? WRITE : GAP;
      end
      DRAIN: nxt = (!Out_Valid || Out_Ready) ? READ : DRAIN;
      READ: begin
        Sel = 1'b1;
        nxt = PARK;
      end
      default: nxt = INIT;
    endcase
    // Hold the bus quiet while reset is asserted, even though state already reads INIT
    Sel = Sel & nRst;
    In_Ready = In_Ready & nRst;
  end
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state <= INIT;
      count <= '0;
      op <= '0;
      Out_Data <= '0;
      Out_Valid <= 1'b0;
    end else begin
      state <= nxt;
      if (In_Valid && In_Ready) op <= In_Data;
      if (state == WRITE) count <= last ? '0 : count + 1'b1;
      if (state == READ) begin
        Out_Data <= Dio;
        Out_Valid <= 1'b1;
      end else if (Out_Ready) Out_Valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_accumulator_sequencer.sv
// tb_accumulator_sequencer: random and directed batches against a batch-sum model and a behavioural accumulator
module tb_accumulator_sequencer;
  logic clk = 0, nrst = 0;
  always #5 clk = ~clk;
  logic iv[2] = '{0, 0}, ordy[2] = '{0, 0};
  logic ir[2], ov[2], sel[2], rnw[2];
  logic [7:0] id[2] = '{0, 0};
  logic [7:0] od[2], acc[2], lastin[2];
  logic flg[2] = '{0, 0}, armed[2] = '{0, 0};
  wire [7:0] dio0, dio1;
  int tests = 0, fails = 0, viol = 0;
  int psum[2] = '{0, 0}, pcnt[2] = '{0, 0};
  int nops[2] = '{4, 1};
  int q0[$], q1[$];
  logic hs_in;
  logic [7:0] last_got;

  accumulator_sequencer #(.N_OPS(4), .CW(8)) u0 (
    .Clk(clk), .nRst(nrst), .In_Data(id[0]), .In_Valid(iv[0]), .In_Ready(ir[0]),
    .Out_Data(od[0]), .Out_Valid(ov[0]), .Out_Ready(ordy[0]), .Sel(sel[0]), .RnW(rnw[0]), .Dio(dio0)
  );
  accumulator_sequencer #(.N_OPS(1), .CW(1)) u1 (
    .Clk(clk), .nRst(nrst), .In_Data(id[1]), .In_Valid(iv[1]), .In_Ready(ir[1]),
    .Out_Data(od[1]), .Out_Valid(ov[1]), .Out_Ready(ordy[1]), .Sel(sel[1]), .RnW(rnw[1]), .Dio(dio1)
  );

  // Accumulator: a write with the load flag set loads, otherwise adds; reads arm the flag, Sel=0 clears it
  assign dio0 = (sel[0] && rnw[0]) ? acc[0] : 8'bz;
  assign dio1 = (sel[1] && rnw[1]) ? acc[1] : 8'bz;
  function automatic logic [7:0] bus(input int k);
    return k == 0 ? dio0 : dio1;
  endfunction
  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      if (!sel[k]) flg[k] <= 0;
      else if (rnw[k]) flg[k] <= 1;
      else begin
        acc[k] <= flg[k] ? bus(k) : acc[k] + bus(k);
        flg[k] <= 0;
      end
    end

  // Bus rules: writes only with Sel=1 and the accepted operand; Sel never drops between a read and the next write
  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      if (!nrst) armed[k] = 0;
      else begin
        if (!rnw[k] && (!sel[k] || ir[k] || bus(k) !== lastin[k])) viol++;
        if (armed[k] && !sel[k]) viol++;
        if (sel[k] && rnw[k] && !ir[k]) armed[k] = 1;
        else if (!rnw[k]) armed[k] = 0;
      end
    end

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return k == 0 ? q0.size() : q1.size();
  endfunction

  task automatic step(input int k, input logic v, input logic [7:0] d, input logic r);
    int e;
    @(negedge clk);
    iv[k] = v;
    id[k] = d;
    ordy[k] = r;
    #1;
    hs_in = v && ir[k];
    if (ov[k] && r) begin
      if (qsize(k) == 0) chk("spurious_out", 1, 0);
      else begin
        if (k == 0) e = q0.pop_front();
        else e = q1.pop_front();
        last_got = od[k];
        chk("sum", od[k], e);
      end
    end
    if (hs_in) begin
      lastin[k] = d;
      psum[k] += d;
      pcnt[k]++;
      if (pcnt[k] == nops[k]) begin
        if (k == 0) q0.push_back(psum[k] % 256);
        else q1.push_back(psum[k] % 256);
        psum[k] = 0;
        pcnt[k] = 0;
      end
    end
  endtask

  task automatic feed(input int k, input logic [7:0] d, input logic r);
    for (int i = 0; i < 64; i++) begin
      step(k, 1, d, r);
      if (hs_in) return;
    end
    chk("feed_timeout", 0, 1);
  endtask

  task automatic flush(input int k);
    step(k, 0, 0, 1);
    for (int i = 0; i < 64 && qsize(k) != 0; i++) step(k, 0, 0, 1);
    chk("flush_done", qsize(k), 0);
  endtask

  task automatic do_reset();
    nrst = 0;
    iv[0] = 0;
    iv[1] = 0;
    psum = '{0, 0};
    pcnt = '{0, 0};
    q0.delete();
    q1.delete();
    step(0, 0, 0, 0);
    chk("rst_in_ready", ir[0], 0);
    chk("rst_sel", sel[0], 0);
    chk("rst_rnw", rnw[0], 1);
    chk("rst_out_valid", ov[0], 0);
    chk("rst_out_data", od[0], 0);
    chk("rst_sel_n1", sel[1], 0);
    nrst = 1;
  endtask

  initial begin
    logic [7:0] b1[4] = '{10, 20, 30, 40};
    logic [7:0] b2[4] = '{1, 2, 3, 4};
    logic [7:0] b3[4] = '{200, 100, 0, 0};
    do_reset();
    for (int i = 0; i < 4; i++) feed(0, b1[i], 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      chk("lat_early", ov[0], 0);
    end
    step(0, 0, 0, 1);
    chk("lat_valid", ov[0], 1);
    chk("sum_100", last_got, 100);
    step(0, 0, 0, 1);
    chk("ov_clear", ov[0], 0);
    for (int i = 0; i < 4; i++) feed(0, b3[i], 1);
    flush(0);
    chk("ovf_sum", last_got, 44);
    for (int i = 0; i < 4; i++) feed(0, b1[i], 1);
    for (int i = 0; i < 4; i++) feed(0, b2[i], 1);
    flush(0);
    chk("b2b_sum", last_got, 10);
    for (int i = 0; i < 4; i++) feed(0, b1[i], 0);
    for (int i = 0; i < 20 && !ov[0]; i++) step(0, 0, 0, 0);
    chk("stall_first", ov[0], 1);
    for (int i = 0; i < 4; i++) feed(0, b2[i], 0);
    repeat (20) step(0, 0, 0, 0);
    chk("stall_ready", ir[0], 0);
    chk("stall_valid", ov[0], 1);
    chk("stall_hold", od[0], 100);
    flush(0);
    chk("stall_second", last_got, 10);
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 3)) step(0, 0, 0, 1'($urandom_range(0, 1)));
        feed(0, 8'($urandom), 1'($urandom_range(0, 1)));
      end
    end
    flush(0);
    feed(0, 8'($urandom), 1);
    feed(0, 8'($urandom), 1);
    do_reset();
    for (int i = 0; i < 4; i++) feed(0, 5, 1);
    flush(0);
    chk("rst_batch", last_got, 20);
    feed(1, 7, 1);
    flush(1);
    chk("n1_sum", last_got, 7);
    feed(1, 200, 1);
    feed(1, 99, 1);
    flush(1);
    chk("n1_b2b", last_got, 99);
    chk("bus_viol", viol, 0);
    chk("queue_empty", q0.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
